// File: rtl/pattern_scan_arbiter.sv
// Four-channel round-robin front end sharing one bit-serial 11011 Mealy detector.
// Each channel keeps its own detector context and saturating match counter.
module pattern_scan_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  input  logic [3:0]  clr_ctx,
  output logic        busy,
  output logic        match_valid,
  output logic [1:0]  match_ch,
  output logic [2:0]  match_bit,
  input  logic [1:0]  cnt_sel,
  output logic [7:0]  cnt_out
);

  // Handshake: a channel raises req[i] with its byte on req_data[8i+7:8i] and holds
  // both until gnt[i]; gnt[i] is a one-cycle pulse and the byte is taken on that edge.
  typedef enum logic [1:0] {IDLE, SHIFT, SAVE} ctl_t;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_t;

  ctl_t       state, state_nxt;
  det_t       det, det_nxt;
  det_t       ctx [4];
  logic [7:0] cnt [4];
  logic [1:0] act, last_gnt, pick, cand;
  logic       pick_ok;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       clr_seen;
  logic       bit_in, det_out;

  always_comb begin
    pick    = 2'd0;
    pick_ok = 1'b0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_gnt + 2'(k);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    bit_in  = shreg[idx];
    det_nxt = S0;
    case (det)
      S0:      det_nxt = bit_in ? S1 : S0;
      S1:      det_nxt = bit_in ? S2 : S0;
      S2:      det_nxt = bit_in ? S2 : S3;
      S3:      det_nxt = bit_in ? S4 : S0;
      S4:      det_nxt = bit_in ? S2 : S0;
      default: det_nxt = S0;
    endcase
    det_out = (det == S4) && bit_in;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_ok) state_nxt = SHIFT;
      SHIFT:   if (idx == 3'd0) state_nxt = SAVE;
      SAVE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are held low during reset so nothing leaks out of a discarded byte.
  assign busy        = (state != IDLE);
  assign match_valid = !rst && (state == SHIFT) && det_out;
  assign match_ch    = act;
  assign match_bit   = idx;
  assign gnt         = (!rst && state == IDLE && pick_ok) ? (4'b0001 << pick) : 4'b0000;
  assign cnt_out     = cnt[cnt_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 2'd3;
      act      <= 2'd0;
      idx      <= 3'd7;
      shreg    <= 8'd0;
      det      <= S0;
      clr_seen <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ctx[i] <= S0;
        cnt[i] <= 8'd0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_ok) begin
          act      <= pick;
          shreg    <= req_data[{pick, 3'b000} +: 8];
          det      <= clr_ctx[pick] ? S0 : ctx[pick];
          idx      <= 3'd7;
          clr_seen <= 1'b0;
        end
        SHIFT: begin
          det <= det_nxt;
          idx <= idx - 3'd1;
          if (clr_ctx[act]) clr_seen <= 1'b1;
        end
        SAVE:    last_gnt <= act;
        default: ;
      endcase
      // A clear of the channel in flight only takes effect on its counter here;
      // its context is overwritten with S0 at SAVE instead.
      for (int i = 0; i < 4; i++) begin
        if (clr_ctx[i]) begin
          cnt[i] <= 8'd0;
          if (state == IDLE || act != 2'(i)) ctx[i] <= S0;
        end else if (state == SHIFT && act == 2'(i) && det_out && cnt[i] != 8'hFF) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
        if (state == SAVE && act == 2'(i))
          ctx[i] <= (clr_seen || clr_ctx[i]) ? S0 : det;
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Bench for pattern_scan_arbiter: directed scenarios plus random multi-channel traffic,
// checked by a monitor against a per-channel bit-history model of the 11011 search.
module tb_pattern_scan_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, gnt, clr_ctx;
  logic [31:0] req_data;
  logic        busy, match_valid;
  logic [1:0]  match_ch, cnt_sel;
  logic [2:0]  match_bit;
  logic [7:0]  cnt_out;

  logic       req_v  [4];
  logic [7:0] data_v [4];
  assign req      = {req_v[3], req_v[2], req_v[1], req_v[0]};
  assign req_data = {data_v[3], data_v[2], data_v[1], data_v[0]};

  pattern_scan_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .clr_ctx(clr_ctx), .busy(busy), .match_valid(match_valid), .match_ch(match_ch),
    .match_bit(match_bit), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // expected matches as {channel, bit index}, in scan order
  logic [4:0] exp_q [$];
  logic [4:0] act_log [$];
  int         gnt_log_ch [$];
  int         gnt_log_cyc [$];

  // reference model: last five bits seen per channel since its last clear
  logic [4:0] m_hist [4];
  int         m_len  [4];
  int         m_cnt  [4];
  int         m_last, m_act, busy_cnt;
  logic       rand_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input int c, input logic [7:0] d);
    for (int b = 7; b >= 0; b--) begin
      m_hist[c] = {m_hist[c][3:0], d[b]};
      if (m_len[c] < 5) m_len[c]++;
      if (m_len[c] == 5 && m_hist[c] == 5'b11011) exp_q.push_back({2'(c), 3'(b)});
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic exp_hit;
    int   e;
    cyc++;
    if (gnt != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (gnt[i]) e = i;
      gnt_log_ch.push_back(e);
      gnt_log_cyc.push_back(cyc);
    end
    if (match_valid) act_log.push_back({match_ch, match_bit});
    if (rst) begin
      chk("gnt_in_reset", {28'd0, gnt}, 0);
      chk("match_in_reset", {31'd0, match_valid}, 0);
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = 5'd0; m_len[i] = 0; m_cnt[i] = 0;
      end
      m_last = 3; m_act = 0; busy_cnt = 0;
      exp_q.delete();
    end else begin
      chk("cnt_out", {24'd0, cnt_out}, m_cnt[cnt_sel]);
      chk("busy", {31'd0, busy}, (busy_cnt > 0) ? 1 : 0);
      exp_hit = (busy_cnt >= 2) && (exp_q.size() > 0) && (exp_q[0] == {2'(m_act), 3'(busy_cnt - 2)});
      if (match_valid || exp_hit) begin
        chk("match_valid", {31'd0, match_valid}, {31'd0, exp_hit});
        if (match_valid && exp_hit) chk("match_ch_bit", {27'd0, match_ch, match_bit}, {27'd0, exp_q[0]});
        if (exp_hit) begin
          if (m_cnt[m_act] < 255) m_cnt[m_act]++;
          void'(exp_q.pop_front());
        end
      end
      for (int i = 0; i < 4; i++) if (clr_ctx[i]) begin
        m_cnt[i] = 0; m_len[i] = 0; m_hist[i] = 5'd0;
      end
      if (busy_cnt == 0 && req != 4'b0000) begin
        e = -1;
        for (int k = 1; k <= 4; k++) if (e < 0 && req[(m_last + k) % 4]) e = (m_last + k) % 4;
        chk("gnt_rr", {28'd0, gnt}, 32'd1 << e);
        chk("exp_q_empty_at_grant", exp_q.size(), 0);
        m_act = e; m_last = e; busy_cnt = 9;
        model_byte(e, data_v[e]);
      end else begin
        chk("gnt_quiet", {28'd0, gnt}, 0);
        if (busy_cnt > 0) busy_cnt--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_ctx = 4'd0;
    for (int i = 0; i < 4; i++) req_v[i] = 1'b0;
    tick(2);
    rst = 1'b0;
    act_log.delete(); gnt_log_ch.delete(); gnt_log_cyc.delete();
  endtask

  // raise req, wait (bounded) for the grant, drop req after the accepting edge
  task automatic send(input int c, input logic [7:0] d);
    logic got = 1'b0;
    req_v[c] = 1'b1; data_v[c] = d;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (gnt[c]) got = 1'b1;
    end
    if (!got) chk("send_timeout", 0, 1);
    tick(1);
    req_v[c] = 1'b0;
  endtask

  task automatic chan(input int c);
    logic [7:0] pat [4] = '{8'hDB, 8'h6D, 8'h1B, 8'hB6};
    repeat (8) begin
      tick(1 + $urandom_range(0, 12));
      send(c, ($urandom_range(0, 1) == 1) ? pat[$urandom_range(0, 3)] : 8'($urandom));
    end
  endtask

  initial begin
    int n;
    logic got;
    rst = 1'b1; clr_ctx = 4'd0; cnt_sel = 2'd0; rand_on = 1'b0;
    for (int i = 0; i < 4; i++) begin req_v[i] = 1'b0; data_v[i] = 8'd0; end

    // ch0 0xDB straight out of reset: grant on first cycle, matches at bits 3 and 0
    req_v[0] = 1'b1; data_v[0] = 8'hDB;
    tick(2);
    rst = 1'b0;
    act_log.delete();
    @(negedge clk);
    chk("t1_first_gnt", {28'd0, gnt}, 32'd1);
    tick(1);
    req_v[0] = 1'b0;
    tick(12);
    cnt_sel = 2'd0;
    @(negedge clk);
    chk("t1_cnt0", {24'd0, cnt_out}, 2);
    chk("t1_nmatch", act_log.size(), 2);
    if (act_log.size() == 2) begin
      chk("t1_match0", {27'd0, act_log[0]}, {27'd0, 5'b00011});
      chk("t1_match1", {27'd0, act_log[1]}, {27'd0, 5'b00000});
    end
    send(0, 8'h60);
    tick(12);
    chk("t1_ctx_s2", act_log.size(), 3);
    if (act_log.size() == 3) chk("t1_ctx_match", {27'd0, act_log[2]}, {27'd0, 5'b00101});

    // pattern across a byte boundary on ch1
    do_reset();
    send(1, 8'h03);
    send(1, 8'h60);
    tick(12);
    cnt_sel = 2'd1;
    @(negedge clk);
    chk("t2_cnt1", {24'd0, cnt_out}, 1);
    chk("t2_nmatch", act_log.size(), 1);
    if (act_log.size() == 1) chk("t2_match", {27'd0, act_log[0]}, {27'd0, 5'b01101});

    // ch2 traffic in between must not disturb ch0 context
    do_reset();
    send(0, 8'h03);
    send(2, 8'hFF);
    send(0, 8'h60);
    tick(12);
    chk("t3_nmatch", act_log.size(), 1);
    if (act_log.size() == 1) chk("t3_match", {27'd0, act_log[0]}, {27'd0, 5'b00101});

    // all channels requesting: order 0,1,2,3,0 every 10 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin req_v[i] = 1'b1; data_v[i] = 8'($urandom); end
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(posedge clk);
      if (gnt_log_ch.size() >= 5) got = 1'b1;
    end
    #1;
    for (int i = 0; i < 4; i++) req_v[i] = 1'b0;
    chk("t4_five_grants", {31'd0, got}, 1);
    if (gnt_log_ch.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        chk("t4_order", gnt_log_ch[i], i % 4);
        if (i > 0) chk("t4_spacing", gnt_log_cyc[i] - gnt_log_cyc[i-1], 10);
      end
    tick(12);

    // saturation at 255 then clear mid-byte
    do_reset();
    n = 0;
    while (m_cnt[2] < 255 && n < 200) begin
      send(2, 8'hDB); tick(10); n++;
    end
    send(2, 8'hDB);
    tick(10);
    cnt_sel = 2'd2;
    @(negedge clk);
    chk("t5_saturated", {24'd0, cnt_out}, 255);
    tick(1);
    send(2, 8'h03);
    tick(2);
    clr_ctx = 4'b0100;
    tick(1);
    clr_ctx = 4'b0000;
    @(negedge clk);
    chk("t5_clr_now", {24'd0, cnt_out}, 0);
    tick(10);
    n = act_log.size();
    send(2, 8'h60);
    tick(12);
    chk("t5_ctx_cleared", act_log.size(), n);

    // clear in the same cycle ch0 is granted: byte scanned from S0
    do_reset();
    send(0, 8'h03);
    tick(10);
    clr_ctx = 4'b0001;
    send(0, 8'h60);
    clr_ctx = 4'b0000;
    tick(12);
    chk("t6_clr_at_grant", act_log.size(), 0);

    // reset during the 4th SHIFT cycle of ch3
    do_reset();
    send(0, 8'hDB);
    tick(10);
    send(3, 8'hDB);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n = act_log.size();
    tick(15);
    chk("t7_no_match_after_rst", act_log.size(), n);
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      @(negedge clk);
      chk("t7_cnt_zero", {24'd0, cnt_out}, 0);
      tick(1);
    end
    req_v[0] = 1'b1; req_v[3] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        got = 1'b1;
        chk("t7_next_gnt_ch0", {28'd0, gnt}, 1);
      end
    end
    if (!got) chk("t7_gnt_timeout", 0, 1);
    tick(1);
    req_v[0] = 1'b0; req_v[3] = 1'b0;
    tick(12);

    // random traffic with random clears and counter selects
    do_reset();
    rand_on = 1'b1;
    fork
      begin
        fork chan(0); chan(1); chan(2); chan(3); join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          tick(1);
          clr_ctx = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
          cnt_sel = 2'($urandom_range(0, 3));
        end
        clr_ctx = 4'd0;
      end
    join
    tick(15);
    chk("final_exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
